// File: rtl/accumulator_pkg.sv
// Shared definitions for the accumulator command sequencer: command
// encodings, the step record layout, the built-in test program and the
// sequencer state type.
package accumulator_pkg;

  localparam logic [1:0] C_HOLD = 2'b00;
  localparam logic [1:0] C_LOAD = 2'b01;
  localparam logic [1:0] C_ADD  = 2'b10;
  localparam logic [1:0] C_CLR  = 2'b11;

  // One program step: the command to issue and the response expected
  // from the accumulator once it has executed that command.
  typedef struct packed {
    logic [1:0] c;
    logic [3:0] d;
    logic [3:0] exp_q;
    logic       exp_carry;
    logic       chk_carry;
  } acc_step_t;

  // The program must open with a load, because the sequencer never
  // resets the accumulator itself. Steps 5..7 only run when NSTEPS > 5.
  localparam acc_step_t ACC_PROGRAM [0:7] = '{
    '{C_LOAD, 4'd5,  4'd5,  1'b0, 1'b0},
    '{C_ADD,  4'd3,  4'd8,  1'b0, 1'b0},
    '{C_ADD,  4'd9,  4'd1,  1'b1, 1'b1},
    '{C_HOLD, 4'd7,  4'd1,  1'b0, 1'b0},
    '{C_CLR,  4'd0,  4'd0,  1'b0, 1'b0},
    '{C_LOAD, 4'd10, 4'd10, 1'b0, 1'b0},
    '{C_ADD,  4'd6,  4'd0,  1'b1, 1'b1},
    '{C_HOLD, 4'd2,  4'd0,  1'b0, 1'b0}
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_ISSUE,
    S_CHECK,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/accumulator_sequencer.sv
// Self-checking command initiator for accumulator_4. Each pacing tick
// issues one program command for a single cycle, waits one cycle for the
// accumulator to update, then compares Q/Carry against the program.
module accumulator_sequencer
  import accumulator_pkg::*;
#(
  parameter int NSTEPS = 8
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_START,
  input  logic       i_TICK,
  input  logic [3:0] i_Q,
  input  logic       i_Carry,
  output logic       o_EN,
  output logic [1:0] o_C,
  output logic [3:0] o_D,
  output logic [2:0] o_STEP,
  output logic       o_BUSY,
  output logic       o_DONE,
  output logic       o_PASS,
  output logic [2:0] o_ERR_STEP
);

  localparam logic [2:0] LAST_STEP = 3'(NSTEPS - 1);

  seq_state_t state;
  seq_state_t next_state;
  logic [2:0] step;
  acc_step_t  cur;
  logic       mismatch;
  logic       run_start;

  assign cur      = ACC_PROGRAM[step];
  assign mismatch = (i_Q != cur.exp_q) ||
                    (cur.chk_carry && (i_Carry != cur.exp_carry));
  assign run_start = ((state == S_IDLE) || (state == S_DONE)) &&
                     (next_state == S_WAIT_TICK);
  assign o_STEP   = step;

  // Next-state logic: ticks only matter in WAIT_TICK, starts only in
  // IDLE/DONE, and the first mismatch or the last step ends the run.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (i_START) next_state = S_WAIT_TICK;
      S_WAIT_TICK: if (i_TICK)  next_state = S_ISSUE;
      S_ISSUE:     next_state = S_CHECK;
      S_CHECK: begin
        if (mismatch || (step == LAST_STEP)) next_state = S_DONE;
        else                                 next_state = S_WAIT_TICK;
      end
      S_DONE:      if (i_START) next_state = S_WAIT_TICK;
      default:     next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_CLK) begin
    if (i_RST) state <= S_IDLE;
    else       state <= next_state;
  end

  // Registered outputs, derived from the upcoming state so that EN is
  // high exactly during the ISSUE cycle and C/D hold between commands.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      o_EN       <= 1'b0;
      o_C        <= '0;
      o_D        <= '0;
      step       <= '0;
      o_BUSY     <= 1'b0;
      o_DONE     <= 1'b0;
      o_PASS     <= 1'b0;
      o_ERR_STEP <= '0;
    end else begin
      o_EN   <= (next_state == S_ISSUE);
      o_BUSY <= (next_state == S_WAIT_TICK) || (next_state == S_ISSUE) ||
                (next_state == S_CHECK);
      o_DONE <= (next_state == S_DONE);
      if (next_state == S_ISSUE) begin
        o_C <= cur.c;
        o_D <= cur.d;
      end
      if (run_start) begin
        step       <= '0;
        o_PASS     <= 1'b0;
        o_ERR_STEP <= '0;
      end else if ((state == S_CHECK) && (next_state == S_WAIT_TICK)) begin
        step <= step + 3'd1;
      end else if ((state == S_CHECK) && (next_state == S_DONE)) begin
        o_PASS     <= !mismatch;
        o_ERR_STEP <= mismatch ? step : 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Bench for accumulator_sequencer: a behavioural accumulator answers the
// issued commands, a scoreboard queue holds the expected command trace,
// and a table of runs plus hand-written corner sequences drive it.
module tb_accumulator_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic       corrupt = 1'b0;

  logic [3:0] mq = 4'd0;
  logic       mc = 1'b0;
  logic [3:0] mq1 = 4'd0;
  logic       mc1 = 1'b0;

  logic       o_EN, o_BUSY, o_DONE, o_PASS;
  logic [1:0] o_C;
  logic [3:0] o_D;
  logic [2:0] o_STEP, o_ERR_STEP;

  logic       e1_EN, e1_BUSY, e1_DONE, e1_PASS;
  logic [1:0] e1_C;
  logic [3:0] e1_D;
  logic [2:0] e1_STEP, e1_ERR_STEP;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int en1_cnt = 0;
  logic prev_en = 1'b0;

  typedef struct {
    logic [1:0] c;
    logic [3:0] d;
    logic [2:0] step;
    logic       chk_d;
  } sb_entry_t;

  sb_entry_t sb[$];

  typedef struct {
    int   gap;
    logic corrupt;
    logic noise;
    int   pulses;
    logic pass;
    int   err_step;
    int   last_step;
    logic chk_one;
  } run_vec_t;

  localparam logic [1:0] EXP_C [5] = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b11};
  localparam logic [3:0] EXP_D [5] = '{4'd5, 4'd3, 4'd9, 4'd7, 4'd0};

  always #5 clk = ~clk;

  accumulator_sequencer #(.NSTEPS(5)) dut (
    .i_CLK(clk), .i_RST(rst), .i_START(start), .i_TICK(tick),
    .i_Q(mq), .i_Carry(mc),
    .o_EN(o_EN), .o_C(o_C), .o_D(o_D), .o_STEP(o_STEP), .o_BUSY(o_BUSY),
    .o_DONE(o_DONE), .o_PASS(o_PASS), .o_ERR_STEP(o_ERR_STEP)
  );

  accumulator_sequencer #(.NSTEPS(1)) dut1 (
    .i_CLK(clk), .i_RST(rst), .i_START(start), .i_TICK(tick),
    .i_Q(mq1), .i_Carry(mc1),
    .o_EN(e1_EN), .o_C(e1_C), .o_D(e1_D), .o_STEP(e1_STEP), .o_BUSY(e1_BUSY),
    .o_DONE(e1_DONE), .o_PASS(e1_PASS), .o_ERR_STEP(e1_ERR_STEP)
  );

  // Reference accumulator: hold, load, add with carry out, clear.
  function automatic logic [4:0] acc_next(input logic [3:0] q, input logic cy,
                                          input logic [1:0] cmd, input logic [3:0] d);
    case (cmd)
      2'b00:   return {cy, q};
      2'b01:   return {1'b0, d};
      2'b10:   return {1'b0, q} + {1'b0, d};
      default: return 5'd0;
    endcase
  endfunction

  // Accumulator beside the five-step sequencer; optionally reports a
  // wrong sum for the add-3 command.
  always @(posedge clk) begin
    if (o_EN) begin
      {mc, mq} <= acc_next(mq, mc, o_C, o_D);
      if (corrupt && (o_C == 2'b10) && (o_D == 4'd3)) mq <= 4'd9;
    end
  end

  // Accumulator beside the single-step sequencer.
  always @(posedge clk) begin
    if (e1_EN) {mc1, mq1} <= acc_next(mq1, mc1, e1_C, e1_D);
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Observe the command bus once per cycle and pop the scoreboard.
  task automatic monitor();
    sb_entry_t e;
    if (o_EN) begin
      en_cnt++;
      checkOutput("en_single_cycle", 32'(prev_en), 32'd0);
      checkOutput("busy_during_en", 32'(o_BUSY), 32'd1);
      if (sb.size() == 0) begin
        checkOutput("unexpected_en", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("issue_c", 32'(o_C), 32'(e.c));
        if (e.chk_d) checkOutput("issue_d", 32'(o_D), 32'(e.d));
        checkOutput("issue_step", 32'(o_STEP), 32'(e.step));
      end
    end
    prev_en = o_EN;
    if (e1_EN) begin
      en1_cnt++;
      checkOutput("one_c", 32'(e1_C), 32'd1);
      checkOutput("one_d", 32'(e1_D), 32'd5);
    end
  endtask

  // Drive inputs for one clock cycle, then sample at the falling edge.
  task automatic applyStimulus(input logic st, input logic tk);
    start = st;
    tick  = tk;
    @(negedge clk);
    monitor();
  endtask

  task automatic push_expected(input int n);
    sb_entry_t e;
    for (int i = 0; i < n; i++) begin
      e.c = EXP_C[i];
      e.d = EXP_D[i];
      e.step = 3'(i);
      e.chk_d = (EXP_C[i] != 2'b11);
      sb.push_back(e);
    end
  endtask

  task automatic drive_until_done(input int gap, input logic noise);
    int cyc = 0;
    logic st, tk;
    while (!o_DONE && cyc < 400) begin
      tk = ((cyc % gap) == (gap - 1)) || (noise && ($urandom_range(0, 1) == 1));
      st = noise && o_BUSY && ($urandom_range(0, 1) == 1);
      applyStimulus(st, tk);
      cyc++;
    end
    checkOutput("run_finished", 32'(o_DONE), 32'd1);
  endtask

  task automatic run_program(input run_vec_t v);
    int base = en_cnt;
    int base1 = en1_cnt;
    corrupt = v.corrupt;
    push_expected(v.pulses);
    applyStimulus(1'b1, 1'b0);
    checkOutput("start_busy", 32'(o_BUSY), 32'd1);
    checkOutput("start_done_clr", 32'(o_DONE), 32'd0);
    checkOutput("start_pass_clr", 32'(o_PASS), 32'd0);
    checkOutput("start_err_clr", 32'(o_ERR_STEP), 32'd0);
    checkOutput("start_step", 32'(o_STEP), 32'd0);
    drive_until_done(v.gap, v.noise);
    checkOutput("end_busy", 32'(o_BUSY), 32'd0);
    checkOutput("end_pass", 32'(o_PASS), 32'(v.pass));
    checkOutput("end_err_step", 32'(o_ERR_STEP), 32'(v.err_step));
    checkOutput("end_step", 32'(o_STEP), 32'(v.last_step));
    checkOutput("en_pulses", 32'(en_cnt - base), 32'(v.pulses));
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    if (v.chk_one) begin
      checkOutput("one_done", 32'(e1_DONE), 32'd1);
      checkOutput("one_pass", 32'(e1_PASS), 32'd1);
      checkOutput("one_step", 32'(e1_STEP), 32'd0);
      checkOutput("one_pulses", 32'(en1_cnt - base1), 32'd1);
    end
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("done_held", 32'(o_DONE), 32'd1);
    corrupt = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_en"}, 32'(o_EN), 32'd0);
    checkOutput({tag, "_c"}, 32'(o_C), 32'd0);
    checkOutput({tag, "_d"}, 32'(o_D), 32'd0);
    checkOutput({tag, "_step"}, 32'(o_STEP), 32'd0);
    checkOutput({tag, "_busy"}, 32'(o_BUSY), 32'd0);
    checkOutput({tag, "_done"}, 32'(o_DONE), 32'd0);
    checkOutput({tag, "_pass"}, 32'(o_PASS), 32'd0);
    checkOutput({tag, "_err"}, 32'(o_ERR_STEP), 32'd0);
  endtask

  run_vec_t vecs [7];

  initial begin
    int base;
    int guard;
    vecs[0] = '{gap: 4, corrupt: 1'b0, noise: 1'b0, pulses: 5, pass: 1'b1, err_step: 0, last_step: 4, chk_one: 1'b1};
    vecs[1] = '{gap: 3, corrupt: 1'b0, noise: 1'b0, pulses: 5, pass: 1'b1, err_step: 0, last_step: 4, chk_one: 1'b1};
    vecs[2] = '{gap: 4, corrupt: 1'b1, noise: 1'b0, pulses: 2, pass: 1'b0, err_step: 1, last_step: 1, chk_one: 1'b1};
    vecs[3] = '{gap: 5, corrupt: 1'b0, noise: 1'b0, pulses: 5, pass: 1'b1, err_step: 0, last_step: 4, chk_one: 1'b1};
    vecs[4] = '{gap: 2, corrupt: 1'b0, noise: 1'b0, pulses: 5, pass: 1'b1, err_step: 0, last_step: 4, chk_one: 1'b1};
    vecs[5] = '{gap: 3, corrupt: 1'b0, noise: 1'b1, pulses: 5, pass: 1'b1, err_step: 0, last_step: 4, chk_one: 1'b0};
    vecs[6] = '{gap: 7, corrupt: 1'b0, noise: 1'b0, pulses: 5, pass: 1'b1, err_step: 0, last_step: 4, chk_one: 1'b1};

    // Reset, then sit idle: nothing may be issued.
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
    base = en_cnt;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, (i % 3) == 0);
    check_all_zero("reset_idle");
    checkOutput("idle_no_en", 32'(en_cnt - base), 32'd0);

    // Start and tick together in IDLE: only the start is taken.
    push_expected(5);
    base = en_cnt;
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("st_tk_no_en", 32'(en_cnt - base), 32'd0);
    checkOutput("st_tk_busy", 32'(o_BUSY), 32'd1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("tick_to_en", 32'(o_EN), 32'd1);
    drive_until_done(3, 1'b0);
    checkOutput("st_tk_pass", 32'(o_PASS), 32'd1);
    checkOutput("st_tk_sb", 32'(sb.size()), 32'd0);

    // Table of complete runs, each restarting from DONE.
    for (int i = 0; i < 7; i++) begin
      $display("[TB] run %0d gap=%0d corrupt=%0d noise=%0d", i, vecs[i].gap,
               vecs[i].corrupt, vecs[i].noise);
      run_program(vecs[i]);
    end

    // Reset during the CHECK cycle of step 2, then rerun from step 0.
    push_expected(5);
    applyStimulus(1'b1, 1'b0);
    guard = 0;
    while (!(o_EN && (o_STEP == 3'd2)) && guard < 100) begin
      applyStimulus(1'b0, (guard % 3) == 2);
      guard++;
    end
    checkOutput("reached_step2", 32'(o_EN && (o_STEP == 3'd2)), 32'd1);
    applyStimulus(1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
    check_all_zero("mid_reset");
    sb.delete();
    base = en_cnt;
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("post_reset_no_en", 32'(en_cnt - base), 32'd0);
    checkOutput("post_reset_busy", 32'(o_BUSY), 32'd0);
    run_program(vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
